// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block type, reduction constant, table limits, FSM states.
// No ports; imported by the interface, the multiplier and hpow_gen.
package gcm_pkg;

    localparam int unsigned BLK_W = 128;

    typedef logic [BLK_W-1:0] block_t;

    // x^128 + x^7 + x^2 + x + 1 in GCM bit-reflected form
    localparam block_t GF_R = {8'hE1, 120'h0};

    localparam int unsigned NUM_POW_MIN = 2;
    localparam int unsigned NUM_POW_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/hpow_gen_if.sv
// Key-in / power-table-out bundle for hpow_gen.
//   h1_i, h1_valid_i  hash key H and its level-held valid
//   GHASH_done        consumer releases the table
//   hpow_o            NUM_POW x 128 power table, slot k at [128k-1:128(k-1)]
//   h_valid, busy     table complete / computation running
interface hpow_gen_if #(
    parameter int unsigned NUM_POW = 8
);
    import gcm_pkg::*;

    block_t                       h1_i;
    logic                         h1_valid_i;
    logic                         GHASH_done;
    logic [NUM_POW*BLK_W-1:0]     hpow_o;
    logic                         h_valid;
    logic                         busy;

    modport master (
        output h1_i, h1_valid_i, GHASH_done,
        input  hpow_o, h_valid, busy
    );

    modport slave (
        input  h1_i, h1_valid_i, GHASH_done,
        output hpow_o, h_valid, busy
    );

endinterface

// File: rtl/gf128_mul_iter.sv
// Digit-serial GF(2^128) multiplier, GCM bit-reflected convention.
//   clk, rst  clock, async active-high reset
//   start     load a, b and process the first digit on this edge
//   a, b      operands (a is scanned DIGIT bits per cycle, MSB first)
//   done      one-cycle pulse when p = a*b is ready
//   p         product, held until the next start
module gf128_mul_iter
    import gcm_pkg::*;
#(
    parameter int unsigned DIGIT = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  block_t a,
    input  block_t b,
    output logic   done,
    output block_t p
);

    localparam int unsigned MUL_CYC = BLK_W / DIGIT;
    localparam int unsigned CNT_W   = 8;

    block_t             z_q, v_q, x_q;
    block_t             z_s, v_s, x_src, x_nxt;
    logic               run_q;
    logic [CNT_W-1:0]   cnt_q;

    // One digit of shift-and-add; a start cycle works directly on the inputs
    always_comb begin
        z_s   = start ? '0 : z_q;
        v_s   = start ? b  : v_q;
        x_src = start ? a  : x_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (x_src[BLK_W-1-i]) begin
                z_s = z_s ^ v_s;
            end
            v_s = v_s[0] ? ((v_s >> 1) ^ GF_R) : (v_s >> 1);
        end
        x_nxt = x_src << DIGIT;
    end

    // Start always wins, so a new request silently cancels any old one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q   <= '0;
            v_q   <= '0;
            x_q   <= '0;
            run_q <= 1'b0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            z_q   <= z_s;
            v_q   <= v_s;
            x_q   <= x_nxt;
            cnt_q <= CNT_W'(MUL_CYC - 1);
            run_q <= (MUL_CYC > 1);
            done  <= (MUL_CYC == 1);
        end else if (run_q) begin
            z_q   <= z_s;
            v_q   <= v_s;
            x_q   <= x_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
            run_q <= (cnt_q != CNT_W'(1));
            done  <= (cnt_q == CNT_W'(1));
        end else begin
            done  <= 1'b0;
        end
    end

    assign p = z_q;

endmodule

// File: rtl/hpow_gen.sv
// Builds the GHASH key power table H^1..H^NUM_POW with one iterative multiplier.
//   clk, rst  clock, async active-high reset
//   bus       hpow_gen_if slave: key in, table/status out
module hpow_gen
    import gcm_pkg::*;
#(
    parameter int unsigned NUM_POW = 8,
    parameter int unsigned DIGIT   = 32
) (
    input  logic       clk,
    input  logic       rst,
    hpow_gen_if.slave  bus
);

    localparam int unsigned K_W = $clog2(NUM_POW + 1);

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    block_t             tbl_q [NUM_POW];
    block_t             tbl_d [NUM_POW];
    logic               hv_q, hv_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               h1v_q;
    logic               rise_c;
    block_t             mul_a;
    logic               mul_done;
    block_t             mul_p;

    assign rise_c = bus.h1_valid_i & ~h1v_q;

    // Multiplier operand: previous power H^(k-1)
    always_comb begin
        mul_a = '0;
        for (int i = 0; i < int'(NUM_POW) - 1; i++) begin
            if (k_q == K_W'(i + 2)) begin
                mul_a = tbl_q[i];
            end
        end
    end

    gf128_mul_iter #(
        .DIGIT (DIGIT)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .a     (mul_a),
        .b     (tbl_q[0]),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Next-state and table update; GHASH_done outranks everything else
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tbl_d   = tbl_q;
        hv_d    = hv_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.GHASH_done && rise_c) begin
                    for (int i = 0; i < int'(NUM_POW); i++) begin
                        tbl_d[i] = '0;
                    end
                    tbl_d[0] = bus.h1_i;
                    k_d      = K_W'(2);
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (bus.GHASH_done) begin
                    for (int i = 0; i < int'(NUM_POW); i++) begin
                        tbl_d[i] = '0;
                    end
                    k_d     = K_W'(2);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (mul_done && !start_q) begin
                    // done during the issue cycle belongs to a cancelled product
                    for (int i = 1; i < int'(NUM_POW); i++) begin
                        if (k_q == K_W'(i + 1)) begin
                            tbl_d[i] = mul_p;
                        end
                    end
                    if (k_q == K_W'(NUM_POW)) begin
                        hv_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + K_W'(1);
                        start_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.GHASH_done) begin
                    for (int i = 0; i < int'(NUM_POW); i++) begin
                        tbl_d[i] = '0;
                    end
                    k_d     = K_W'(2);
                    hv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= K_W'(2);
            for (int i = 0; i < int'(NUM_POW); i++) begin
                tbl_q[i] <= '0;
            end
            hv_q    <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            h1v_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tbl_q   <= tbl_d;
            hv_q    <= hv_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            h1v_q   <= bus.h1_valid_i;
        end
    end

    for (genvar g = 0; g < int'(NUM_POW); g++) begin : g_out
        assign bus.hpow_o[g*BLK_W +: BLK_W] = tbl_q[g];
    end

    assign bus.h_valid = hv_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_hpow_gen.sv
// Scoreboard bench for hpow_gen: three configurations run side by side.
//   a: NUM_POW=4 DIGIT=32, b: NUM_POW=8 DIGIT=32, c: NUM_POW=2 DIGIT=1
module tb_hpow_gen;

    localparam logic [127:0] H_A = 128'hacbef20579b4b8ebce889bac8732dad7;
    localparam logic [127:0] A2  = 128'hdb9f3b4948607beb8bb753ba40ab627b;
    localparam logic [127:0] A4  = 128'hb94efa0be54358f908c0c7fc88d48db2;
    localparam logic [127:0] H_B = 128'hb83b533708bf535d0aa6e52980d53b78;
    localparam logic [127:0] B2  = 128'h8a6ff5aca561c0d865805055eb728397;
    localparam logic [127:0] B4  = 128'h3c4b0daa91e6b35f9b9e89d8510dd431;
    localparam logic [127:0] H_C = 128'h466923ec9ae682214f2c082badb39249;
    localparam logic [127:0] C2  = 128'hfeb4f24b48eba65cf94280b1f68220a0;

    // 1 + (NUM_POW-1)*(128/DIGIT + 1)
    localparam int LAT_A = 16;
    localparam int LAT_B = 36;
    localparam int LAT_C = 130;

    typedef struct {
        int            npow;
        logic [2047:0] tbl;
        int            at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    hpow_gen_if #(.NUM_POW(4)) ba ();
    hpow_gen_if #(.NUM_POW(8)) bb ();
    hpow_gen_if #(.NUM_POW(2)) bc ();

    hpow_gen #(.NUM_POW(4), .DIGIT(32)) u_a (.clk(clk), .rst(rst), .bus(ba.slave));
    hpow_gen #(.NUM_POW(8), .DIGIT(32)) u_b (.clk(clk), .rst(rst), .bus(bb.slave));
    hpow_gen #(.NUM_POW(2), .DIGIT(1))  u_c (.clk(clk), .rst(rst), .bus(bc.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial reference multiply (GCM algorithm 1)
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 127; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [2047:0] tbl_a();
        logic [2047:0] t;
        t = '0;
        t[127:0]   = H_A;
        t[255:128] = A2;
        t[383:256] = gf_mul(A2, H_A);
        t[511:384] = A4;
        return t;
    endfunction

    // Powers of H_B, first n slots kept
    function automatic logic [2047:0] tbl_hb(input int n);
        logic [2047:0] t;
        logic [127:0]  pw;
        t = '0;
        t[127:0]   = H_B;
        t[255:128] = B2;
        t[383:256] = gf_mul(B2, H_B);
        t[511:384] = B4;
        pw = B4;
        for (int k = 5; k <= 8; k++) begin
            pw = gf_mul(pw, H_B);
            t[(k-1)*128 +: 128] = pw;
        end
        for (int k = n + 1; k <= 16; k++) t[(k-1)*128 +: 128] = '0;
        return t;
    endfunction

    function automatic logic [2047:0] tbl_c();
        logic [2047:0] t;
        t = '0;
        t[127:0]   = H_C;
        t[255:128] = C2;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int n, input logic [2047:0] t, input int lat);
        exp_t e;
        e.npow = n;
        e.tbl  = t;
        e.at   = cyc + lat;
        case (d)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic cmp_tab(input string nm, input exp_t e, input logic [2047:0] act, input logic busy);
        for (int k = 1; k <= e.npow; k++)
            chk($sformatf("%s_slot%0d", nm, k), act[(k-1)*128 +: 128], e.tbl[(k-1)*128 +: 128]);
        chk({nm, "_hvalid_cycle"}, 128'(cyc), 128'(e.at));
        chk({nm, "_busy_at_hvalid"}, 128'(busy), 128'(0));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (qa.size() + qb.size() + qc.size()) > 0; i++)
            @(negedge clk);
        chk("drain_pending", 128'(qa.size() + qb.size() + qc.size()), 128'(0));
    endtask

    // Monitors: every h_valid rise must match the oldest pending table
    logic hv_pa = 1'b0;
    logic hv_pb = 1'b0;
    logic hv_pc = 1'b0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ba.h_valid && !hv_pa) begin
            if (qa.size() == 0) chk("a_unexpected_hvalid", 128'(ba.h_valid), 128'(0));
            else begin
                e = qa.pop_front();
                cmp_tab("a", e, 2048'(ba.hpow_o), ba.busy);
            end
        end
        hv_pa = ba.h_valid;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (bb.h_valid && !hv_pb) begin
            if (qb.size() == 0) chk("b_unexpected_hvalid", 128'(bb.h_valid), 128'(0));
            else begin
                e = qb.pop_front();
                cmp_tab("b", e, 2048'(bb.hpow_o), bb.busy);
            end
        end
        hv_pb = bb.h_valid;
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (bc.h_valid && !hv_pc) begin
            if (qc.size() == 0) chk("c_unexpected_hvalid", 128'(bc.h_valid), 128'(0));
            else begin
                e = qc.pop_front();
                cmp_tab("c", e, 2048'(bc.hpow_o), bc.busy);
            end
        end
        hv_pc = bc.h_valid;
    end

    initial begin
        ba.h1_i = '0; ba.h1_valid_i = 1'b0; ba.GHASH_done = 1'b0;
        bb.h1_i = '0; bb.h1_valid_i = 1'b0; bb.GHASH_done = 1'b0;
        bc.h1_i = '0; bc.h1_valid_i = 1'b0; bc.GHASH_done = 1'b0;
        tick(3);

        // Reset state
        chk("rst_a_tbl", 128'(ba.hpow_o != '0), 128'(0));
        chk("rst_b_tbl", 128'(bb.hpow_o != '0), 128'(0));
        chk("rst_c_tbl", 128'(bc.hpow_o != '0), 128'(0));
        chk("rst_flags", {122'b0, ba.h_valid, ba.busy, bb.h_valid, bb.busy, bc.h_valid, bc.busy}, 128'(0));
        rst = 1'b0;
        tick(2);

        // Three keys at once
        ba.h1_i = H_A; bb.h1_i = H_B; bc.h1_i = H_C;
        push(0, 4, tbl_a(), LAT_A);
        push(1, 8, tbl_hb(8), LAT_B);
        push(2, 2, tbl_c(), LAT_C);
        ba.h1_valid_i = 1'b1; bb.h1_valid_i = 1'b1; bc.h1_valid_i = 1'b1;
        tick(1);
        chk("start_busy", {125'b0, ba.busy, bb.busy, bc.busy}, 128'h7);
        chk("start_a_slot1", ba.hpow_o[127:0], H_A);
        chk("start_a_slot2_zero", ba.hpow_o[255:128], 128'(0));
        chk("start_c_slot2_zero", bc.hpow_o[255:128], 128'(0));
        wait_drain(300);

        // DONE ignores new key values
        ba.h1_i = 128'h0123456789abcdef0123456789abcdef;
        tick(3);
        chk("done_a_slot1_held", ba.hpow_o[127:0], H_A);
        chk("done_a_slot4_held", ba.hpow_o[511:384], A4);
        chk("done_a_hvalid", 128'(ba.h_valid), 128'(1));

        // Release all tables with h1_valid_i still high
        ba.GHASH_done = 1'b1; bb.GHASH_done = 1'b1; bc.GHASH_done = 1'b1;
        tick(1);
        ba.GHASH_done = 1'b0; bb.GHASH_done = 1'b0; bc.GHASH_done = 1'b0;
        chk("rel_hvalid", {125'b0, ba.h_valid, bb.h_valid, bc.h_valid}, 128'(0));
        chk("rel_a_tbl", 128'(ba.hpow_o != '0), 128'(0));
        chk("rel_b_tbl", 128'(bb.hpow_o != '0), 128'(0));
        tick(10);
        chk("held_level_b_busy", 128'(bb.busy), 128'(0));
        chk("held_level_b_tbl", 128'(bb.hpow_o != '0), 128'(0));

        // New edge on b; abort on a, then restart a with H_B
        ba.h1_valid_i = 1'b0; bb.h1_valid_i = 1'b0; bc.h1_valid_i = 1'b0;
        tick(2);
        push(1, 8, tbl_hb(8), LAT_B);
        bb.h1_valid_i = 1'b1;
        ba.h1_i = H_A;
        ba.h1_valid_i = 1'b1;
        tick(7);
        chk("abort_a_busy_before", 128'(ba.busy), 128'(1));
        ba.GHASH_done = 1'b1;
        tick(1);
        ba.GHASH_done = 1'b0;
        chk("abort_a_busy", 128'(ba.busy), 128'(0));
        chk("abort_a_hvalid", 128'(ba.h_valid), 128'(0));
        chk("abort_a_tbl", 128'(ba.hpow_o != '0), 128'(0));
        tick(5);
        chk("abort_a_stays_idle", 128'(ba.busy), 128'(0));
        ba.h1_valid_i = 1'b0;
        tick(1);
        ba.h1_i = H_B;
        push(0, 4, tbl_hb(4), LAT_A);
        ba.h1_valid_i = 1'b1;
        wait_drain(300);

        tick(1);
        ba.GHASH_done = 1'b1; bb.GHASH_done = 1'b1;
        tick(1);
        ba.GHASH_done = 1'b0; bb.GHASH_done = 1'b0;
        ba.h1_valid_i = 1'b0; bb.h1_valid_i = 1'b0;
        tick(2);

        // Asynchronous reset in the middle of c's long multiply
        bc.h1_i = H_C;
        bc.h1_valid_i = 1'b1;
        tick(20);
        chk("c_busy_before_rst", 128'(bc.busy), 128'(1));
        chk("c_slot1_before_rst", bc.hpow_o[127:0], H_C);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_c_busy", 128'(bc.busy), 128'(0));
        chk("async_rst_c_tbl", 128'(bc.hpow_o != '0), 128'(0));
        chk("async_rst_c_hvalid", 128'(bc.h_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        push(2, 2, tbl_c(), LAT_C);
        wait_drain(300);

        // GHASH_done and a start edge together in IDLE: no start
        tick(1);
        bc.GHASH_done = 1'b1;
        tick(1);
        bc.GHASH_done = 1'b0;
        bc.h1_valid_i = 1'b0;
        ba.h1_i = H_A;
        ba.h1_valid_i = 1'b1;
        ba.GHASH_done = 1'b1;
        tick(1);
        ba.GHASH_done = 1'b0;
        chk("prio_a_busy", 128'(ba.busy), 128'(0));
        tick(3);
        chk("prio_a_still_idle", 128'(ba.busy), 128'(0));
        chk("prio_a_tbl", 128'(ba.hpow_o != '0), 128'(0));
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hpow_gen.md
HPOW_GEN -- requirements
Module: hpow_gen

Interface
REQ-001 Parameter NUM_POW, default 8, number of hash-key powers H^1..H^NUM_POW produced; legal range 2..16.
REQ-002 Parameter DIGIT, default 32, multiplier bits consumed per cycle; legal values 1, 2, 4, 8, 16, 32, 64, 128. MUL_CYC = 128/DIGIT.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 h1_i  input  128  hash key H (GCM bit-reflected order).
REQ-006 h1_valid_i  input  1  H present; level held by the source.
REQ-007 GHASH_done  input  1  consumer finished with the table; releases it.
REQ-008 hpow_o  output  NUM_POW*128  power table; bits [128k-1:128(k-1)] = H^k.
REQ-009 h_valid  output  1  table complete and stable.
REQ-010 busy  output  1  computation in progress.

Function
REQ-011 Multiplication is in GF(2^128), polynomial x^128+x^7+x^2+x+1, GCM bit-reflected convention (reduction constant 0xE1 followed by 120 zero bits).
REQ-012 FSM states: IDLE, MUL, DONE.
REQ-013 Start condition: in IDLE, h1_valid_i=1 and its registered copy = 0 (rising edge). A level held high after GHASH_done does not restart the computation.
REQ-014 On start: latch h1_i into slot 1, clear slots 2..NUM_POW, k=2, issue multiplier start, enter MUL, busy=1.
REQ-015 In MUL: on multiplier done, write product H^(k-1)·H into slot k. If k==NUM_POW, enter DONE. Otherwise increment k and issue the next start on the following cycle.
REQ-016 Each multiply takes exactly MUL_CYC cycles from start to done, plus 1 issue cycle.
REQ-017 h_valid rises exactly 1+(NUM_POW-1)*(MUL_CYC+1) cycles after the start edge. busy falls on the same edge.
REQ-018 DONE: h_valid=1, hpow_o held constant; h1_i changes are ignored.
REQ-019 GHASH_done=1 in DONE: next edge clears h_valid and all slots, enters IDLE.
REQ-020 GHASH_done=1 in MUL: abort; multiplier is cancelled, slots are cleared, FSM enters IDLE, busy=0, h_valid never asserts for that key.
REQ-021 GHASH_done and a start edge on the same cycle in IDLE: GHASH_done has priority and no start occurs.
REQ-022 hpow_o slots not yet written read as zero. Partial results are visible but are valid only when h_valid=1.

Reset
REQ-023 rst=1 asynchronously forces: FSM=IDLE, k=2, hpow_o=0, h_valid=0, busy=0, registered h1_valid=0, multiplier idle.
REQ-024 Reset mid-MUL discards all partial products. After release, a still-high h1_valid_i counts as a new rising edge.

Structure
REQ-025 Shared package gcm_pkg holds: block_t (128-bit), GF_R constant, NUM_POW range limits.
REQ-026 One sub-module, gf128_mul_iter (ports clk, rst, start, a, b, done, p; parameter DIGIT). It is the only GF arithmetic; the power table and FSM live in hpow_gen.
REQ-027 Multiplier done is a one-cycle pulse; p holds until the next start.

Verification
REQ-028 NUM_POW=4, DIGIT=32, H=acbef20579b4b8ebce889bac8732dad7 -> slot1=H, slot2=db9f3b4948607beb8bb753ba40ab627b, slot4=b94efa0be54358f908c0c7fc88d48db2; h_valid at cycle 16.
REQ-029 NUM_POW=8, H=b83b533708bf535d0aa6e52980d53b78 -> slot2=8a6ff5aca561c0d865805055eb728397, slot4=3c4b0daa91e6b35f9b9e89d8510dd431; every slot k equals the reference-model H^k.
REQ-030 NUM_POW=2, DIGIT=1, H=466923ec9ae682214f2c082badb39249 -> slot2=feb4f24b48eba65cf94280b1f68220a0; h_valid at cycle 130.
REQ-031 Pulse GHASH_done mid-MUL -> busy=0 next cycle, hpow_o=0, h_valid stays 0. Then a new h1_valid_i edge -> correct table.
REQ-032 Hold h1_valid_i high through GHASH_done release -> FSM stays IDLE, no recompute; drop and re-raise h1_valid_i -> recompute.
REQ-033 Assert rst mid-MUL -> all outputs 0 immediately, without waiting for a clock edge.
